control_unit: RTL and testbench

- Instruction sequencer for the deep-learning accelerator.
- Each enabled cycle it takes the instruction word addressed by pc and runs one of four operations:
  - NOP.
  - MVIN: byte-wise block copy from DRAM to the unified buffer (UB).
  - MVOUT: byte-wise block copy from UB to DRAM.
  - QUANT: loads the shift amount and zero point for the normalization stage from UB.
- pc advances by one when an instruction completes.
- Sits between the instruction memory, the byte-addressed DRAM model, the UB and the Normalization block.

---
 rtl/control_unit.sv | 269 ++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Instruction sequencer: runs the word at pc as NOP, MVIN (DRAM->UB), MVOUT (UB->DRAM)
// or QUANT (load norm shift/zero point from UB), one byte per two cycles for block moves.
module control_unit #(
    parameter int DRAM_DATA_WIDTH = 128,
    parameter int DRAM_ADDR_WIDTH = 4,
    parameter int SA_LENGTH       = 10,
    parameter int UB_ADDR_WIDTH   = 4,
    parameter int UB_NO_BANKS     = 4,
    parameter int IM_ADDR_WIDTH   = 32,
    localparam int DBW  = DRAM_DATA_WIDTH / 8,
    localparam int COLW = $clog2(DBW),
    localparam int ROWW = DRAM_ADDR_WIDTH,
    localparam int DAW  = DRAM_ADDR_WIDTH + COLW,
    localparam int SAW  = $clog2(SA_LENGTH),
    localparam int UAW  = UB_ADDR_WIDTH + $clog2(UB_NO_BANKS) + SAW,
    localparam int IW   = 3 + DAW + UAW + COLW + ROWW
) (
    input  logic                     CLK,
    input  logic                     ASYNC_RST,
    input  logic                     SYNC_RST,
    input  logic                     EN,
    input  logic [IW-1:0]            instruction,
    output logic [IM_ADDR_WIDTH-1:0] pc,
    output logic                     DRAM_en,
    output logic [DAW-1:0]           DRAM_rdaddr,
    input  logic [7:0]               DRAM_rddata,
    output logic                     DRAM_wren,
    output logic [DAW-1:0]           DRAM_wraddr,
    output logic [7:0]               DRAM_wrdata,
    output logic                     UB_en,
    output logic [UAW-1:0]           UB_rdaddr,
    input  logic [7:0]               UB_rddata,
    output logic                     UB_wren,
    output logic [UAW-1:0]           UB_wraddr,
    output logic [7:0]               UB_wrdata,
    output logic [7:0]               NORM_shift_ammount,
    output logic [7:0]               NORM_z
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_QA, S_QB, S_QC, S_DONE} state_t;

    localparam logic [2:0] OP_MVIN  = 3'b001;
    localparam logic [2:0] OP_MVOUT = 3'b010;
    localparam logic [2:0] OP_QUANT = 3'b011;

    state_t                   state_q, state_d;
    logic [IM_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [IW-1:0]            instr_q, instr_d;
    logic [ROWW-1:0]          r_q, r_d;
    logic [COLW-1:0]          c_q, c_d;
    logic                     dram_en_q, dram_en_d;
    logic                     dram_wren_q, dram_wren_d;
    logic [DAW-1:0]           dram_rdaddr_q, dram_rdaddr_d;
    logic [DAW-1:0]           dram_wraddr_q, dram_wraddr_d;
    logic                     ub_en_q, ub_en_d;
    logic                     ub_wren_q, ub_wren_d;
    logic [UAW-1:0]           ub_rdaddr_q, ub_rdaddr_d;
    logic [UAW-1:0]           ub_wraddr_q, ub_wraddr_d;
    logic [7:0]               norm_shift_q, norm_shift_d;
    logic [7:0]               norm_z_q, norm_z_d;

    // Fields come from the live input while IDLE so the first element address is ready at the latch edge.
    logic [IW-1:0]   ins;
    logic [2:0]      op;
    logic [DAW-1:0]  fa;
    logic [UAW-1:0]  fb;
    logic [COLW-1:0] cols, c_nxt;
    logic [ROWW-1:0] rows, r_nxt;
    logic [UAW-1:0]  src_shift, src_z;
    logic            issue_rd, issue_wr;

    assign ins       = (state_q == S_IDLE) ? instruction : instr_q;
    assign op        = ins[IW-1 -: 3];
    assign fa        = ins[IW-4 -: DAW];
    assign fb        = ins[COLW+ROWW +: UAW];
    assign cols      = ins[ROWW +: COLW];
    assign rows      = ins[0 +: ROWW];
    assign src_shift = ins[UAW +: UAW];
    assign src_z     = ins[0 +: UAW];
    assign c_nxt     = c_q + COLW'(1);
    assign r_nxt     = r_q + ROWW'(1);

    function automatic logic [DAW-1:0] dram_elem(input logic [DAW-1:0] base,
                                                 input logic [ROWW-1:0] r,
                                                 input logic [COLW-1:0] c);
        return base + {r, {COLW{1'b0}}} + DAW'(c);
    endfunction

    // UB rows are laid out on a power-of-two stride covering one SA_LENGTH-byte word.
    function automatic logic [UAW-1:0] ub_elem(input logic [UAW-1:0] base,
                                               input logic [ROWW-1:0] r,
                                               input logic [COLW-1:0] c);
        return base + (UAW'(r) << SAW) + UAW'(c);
    endfunction

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        r_d           = r_q;
        c_d           = c_q;
        dram_en_d     = 1'b0;
        dram_wren_d   = 1'b0;
        ub_en_d       = 1'b0;
        ub_wren_d     = 1'b0;
        dram_rdaddr_d = dram_rdaddr_q;
        dram_wraddr_d = dram_wraddr_q;
        ub_rdaddr_d   = ub_rdaddr_q;
        ub_wraddr_d   = ub_wraddr_q;
        norm_shift_d  = norm_shift_q;
        norm_z_d      = norm_z_q;
        issue_rd      = 1'b0;
        issue_wr      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (EN) begin
                    instr_d = instruction;
                    r_d     = '0;
                    c_d     = '0;
                    case (op)
                        OP_MVIN, OP_MVOUT: begin
                            if (rows == '0 || cols == '0) begin
                                state_d = S_DONE;
                            end else begin
                                state_d  = S_RD;
                                issue_rd = 1'b1;
                            end
                        end
                        OP_QUANT: begin
                            state_d     = S_QA;
                            ub_en_d     = 1'b1;
                            ub_rdaddr_d = src_shift;
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end
            S_RD: begin
                state_d  = S_WR;
                issue_wr = 1'b1;
            end
            S_WR: begin
                if (c_nxt != cols) begin
                    c_d      = c_nxt;
                    state_d  = S_RD;
                    issue_rd = 1'b1;
                end else if (r_nxt != rows) begin
                    c_d      = '0;
                    r_d      = r_nxt;
                    state_d  = S_RD;
                    issue_rd = 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_QA: begin
                state_d     = S_QB;
                ub_en_d     = 1'b1;
                ub_rdaddr_d = src_z;
            end
            S_QB: begin
                state_d      = S_QC;
                norm_shift_d = UB_rddata;
            end
            S_QC: begin
                state_d  = S_DONE;
                norm_z_d = UB_rddata;
            end
            S_DONE: begin
                pc_d    = pc_q + IM_ADDR_WIDTH'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (issue_rd) begin
            if (op == OP_MVIN) begin
                dram_en_d     = 1'b1;
                dram_rdaddr_d = dram_elem(fa, r_d, c_d);
            end else begin
                ub_en_d     = 1'b1;
                ub_rdaddr_d = ub_elem(fb, r_d, c_d);
            end
        end
        if (issue_wr) begin
            if (op == OP_MVIN) begin
                ub_en_d     = 1'b1;
                ub_wren_d   = 1'b1;
                ub_wraddr_d = ub_elem(fb, r_d, c_d);
            end else begin
                dram_en_d     = 1'b1;
                dram_wren_d   = 1'b1;
                dram_wraddr_d = dram_elem(fa, r_d, c_d);
            end
        end

        if (SYNC_RST) begin
            state_d       = S_IDLE;
            pc_d          = '0;
            instr_d       = '0;
            r_d           = '0;
            c_d           = '0;
            dram_en_d     = 1'b0;
            dram_wren_d   = 1'b0;
            ub_en_d       = 1'b0;
            ub_wren_d     = 1'b0;
            dram_rdaddr_d = '0;
            dram_wraddr_d = '0;
            ub_rdaddr_d   = '0;
            ub_wraddr_d   = '0;
            norm_shift_d  = '0;
            norm_z_d      = '0;
        end
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            instr_q       <= '0;
            r_q           <= '0;
            c_q           <= '0;
            dram_en_q     <= 1'b0;
            dram_wren_q   <= 1'b0;
            ub_en_q       <= 1'b0;
            ub_wren_q     <= 1'b0;
            dram_rdaddr_q <= '0;
            dram_wraddr_q <= '0;
            ub_rdaddr_q   <= '0;
            ub_wraddr_q   <= '0;
            norm_shift_q  <= '0;
            norm_z_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            r_q           <= r_d;
            c_q           <= c_d;
            dram_en_q     <= dram_en_d;
            dram_wren_q   <= dram_wren_d;
            ub_en_q       <= ub_en_d;
            ub_wren_q     <= ub_wren_d;
            dram_rdaddr_q <= dram_rdaddr_d;
            dram_wraddr_q <= dram_wraddr_d;
            ub_rdaddr_q   <= ub_rdaddr_d;
            ub_wraddr_q   <= ub_wraddr_d;
            norm_shift_q  <= norm_shift_d;
            norm_z_q      <= norm_z_d;
        end
    end

    assign pc                 = pc_q;
    assign DRAM_en            = dram_en_q;
    assign DRAM_wren          = dram_wren_q;
    assign DRAM_rdaddr        = dram_rdaddr_q;
    assign DRAM_wraddr        = dram_wraddr_q;
    assign UB_en              = ub_en_q;
    assign UB_wren            = ub_wren_q;
    assign UB_rdaddr          = ub_rdaddr_q;
    assign UB_wraddr          = ub_wraddr_q;
    assign NORM_shift_ammount = norm_shift_q;
    assign NORM_z             = norm_z_q;

    // Read data only arrives during the write cycle, so the byte is forwarded rather than registered.
    assign UB_wrdata   = (state_q == S_WR && op == OP_MVIN)  ? DRAM_rddata : 8'h00;
    assign DRAM_wrdata = (state_q == S_WR && op == OP_MVOUT) ? UB_rddata   : 8'h00;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: memory models plus write scoreboards fed by the stimulus tasks.
module tb_control_unit;
    localparam int IW = 29;

    logic          CLK = 1'b0;
    logic          ASYNC_RST, SYNC_RST, EN;
    logic [IW-1:0] instruction;
    logic [31:0]   pc;
    logic          DRAM_en, DRAM_wren, UB_en, UB_wren;
    logic [7:0]    DRAM_rdaddr, DRAM_wraddr, DRAM_rddata, DRAM_wrdata;
    logic [9:0]    UB_rdaddr, UB_wraddr;
    logic [7:0]    UB_rddata, UB_wrdata, NORM_shift_ammount, NORM_z;

    typedef struct { logic [15:0] addr; logic [7:0] data; } wr_t;
    wr_t ub_exp[$];
    wr_t dram_exp[$];

    int n_chk = 0, n_pass = 0, ub_wr_cnt = 0, dram_wr_cnt = 0;
    logic [IW-1:0] imem [0:7];
    logic [7:0]    dram [0:255];
    logic [7:0]    ub   [0:1023];

    control_unit dut (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN),
        .instruction(instruction), .pc(pc),
        .DRAM_en(DRAM_en), .DRAM_rdaddr(DRAM_rdaddr), .DRAM_rddata(DRAM_rddata),
        .DRAM_wren(DRAM_wren), .DRAM_wraddr(DRAM_wraddr), .DRAM_wrdata(DRAM_wrdata),
        .UB_en(UB_en), .UB_rdaddr(UB_rdaddr), .UB_rddata(UB_rddata),
        .UB_wren(UB_wren), .UB_wraddr(UB_wraddr), .UB_wrdata(UB_wrdata),
        .NORM_shift_ammount(NORM_shift_ammount), .NORM_z(NORM_z)
    );

    always #5 CLK = ~CLK;

    assign instruction = imem[pc[2:0]];

    function automatic logic [7:0] nib_sum(input logic [7:0] a);
        return 8'(a[7:4]) + 8'(a[3:0]);
    endfunction

    function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic [7:0] a,
                                         input logic [9:0] b, input logic [3:0] c,
                                         input logic [3:0] r);
        return {op, a, b, c, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Synchronous one-cycle-latency memories; DRAM is preloaded while ASYNC_RST is low.
    always @(posedge CLK) begin
        if (!ASYNC_RST) begin
            for (int i = 0; i < 256; i++) dram[i] <= nib_sum(8'(i));
        end else begin
            if (DRAM_en) begin
                DRAM_rddata <= dram[DRAM_rdaddr];
                if (DRAM_wren) dram[DRAM_wraddr] <= DRAM_wrdata;
            end
        end
        if (UB_en) begin
            UB_rddata <= ub[UB_rdaddr];
            if (UB_wren) ub[UB_wraddr] <= UB_wrdata;
        end
    end

    always @(negedge CLK) begin
        wr_t e;
        if (UB_wren) begin
            ub_wr_cnt++;
            chk("ub_wr_expected", 32'(ub_exp.size() != 0), 32'd1);
            if (ub_exp.size() != 0) begin
                e = ub_exp.pop_front();
                chk("ub_wraddr", 32'(UB_wraddr), 32'(e.addr));
                chk("ub_wrdata", 32'(UB_wrdata), 32'(e.data));
            end
        end
        if (DRAM_wren) begin
            dram_wr_cnt++;
            chk("dram_wr_expected", 32'(dram_exp.size() != 0), 32'd1);
            if (dram_exp.size() != 0) begin
                e = dram_exp.pop_front();
                chk("dram_wraddr", 32'(DRAM_wraddr), 32'(e.addr));
                chk("dram_wrdata", 32'(DRAM_wrdata), 32'(e.data));
            end
        end
    end

    task automatic push_mv(input bit to_ub, input logic [7:0] a, input logic [9:0] b,
                           input int cols, input int rows, input int limit);
        int n;
        wr_t e;
        logic [7:0] da;
        logic [9:0] ua;
        n = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                da = a + 8'(r * 16 + c);
                ua = b + 10'(r * 16 + c);
                e.data = nib_sum(da);
                if (n < limit) begin
                    if (to_ub) begin e.addr = 16'(ua); ub_exp.push_back(e); end
                    else begin e.addr = 16'(da); dram_exp.push_back(e); end
                end
                n++;
            end
        end
    endtask

    // Counts edges from the IDLE latch edge (inclusive) to the edge where pc moves.
    task automatic run(input string tag, input int exp_lat);
        logic [31:0] pc0;
        int cnt;
        bit moved;
        pc0 = pc; cnt = 0; moved = 0;
        @(negedge CLK);
        EN = 1'b1;
        while (!moved && cnt < 200) begin
            @(posedge CLK); #1;
            cnt++;
            if (pc != pc0) moved = 1;
        end
        EN = 1'b0;
        chk({tag, "_lat"}, 32'(cnt), 32'(exp_lat));
        chk({tag, "_pc"}, pc, pc0 + 32'd1);
        chk({tag, "_ub_drain"}, 32'(ub_exp.size()), 32'd0);
        chk({tag, "_dram_drain"}, 32'(dram_exp.size()), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_strobes"}, {28'd0, DRAM_en, DRAM_wren, UB_en, UB_wren}, 32'd0);
        chk({tag, "_norm"}, {16'd0, NORM_shift_ammount, NORM_z}, 32'd0);
        chk({tag, "_pc"}, pc, 32'd0);
    endtask

    initial begin
        int base, cnt;
        ASYNC_RST = 1'b0; SYNC_RST = 1'b0; EN = 1'b0;
        imem[0] = mk(3'b001, 8'h23, 10'h0E0, 4'd3, 4'd3);
        imem[1] = mk(3'b010, 8'h23, 10'h0E0, 4'd3, 4'd3);
        imem[2] = {3'b011, 6'd0, 10'h0E0, 10'h0E1};
        imem[3] = mk(3'b001, 8'h00, 10'h200, 4'd3, 4'd0);
        imem[4] = mk(3'b000, 8'h00, 10'h000, 4'd0, 4'd0);
        imem[5] = mk(3'b001, 8'h23, 10'h300, 4'd3, 4'd3);
        imem[6] = '0;
        imem[7] = '0;

        repeat (3) @(negedge CLK);
        chk_idle("rst_held");
        chk("rst_addr", {DRAM_rdaddr, DRAM_wraddr, 6'd0, UB_rdaddr}, 32'd0);
        ASYNC_RST = 1'b1;
        repeat (20) @(negedge CLK);
        chk_idle("rst_idle20");

        push_mv(1'b1, 8'h23, 10'h0E0, 3, 3, 9);
        run("mvin", 20);
        push_mv(1'b0, 8'h23, 10'h0E0, 3, 3, 9);
        run("mvout", 20);
        run("quant", 5);
        chk("norm_shift", 32'(NORM_shift_ammount), 32'd5);
        chk("norm_z", 32'(NORM_z), 32'd6);
        run("mvin_rows0", 2);
        run("nop", 2);
        repeat (10) @(negedge CLK);
        chk("en_low_pc", pc, 32'd5);
        chk("norm_hold", {16'd0, NORM_shift_ammount, NORM_z}, 32'h0506);

        // Abort a 3x3 MVIN with a synchronous reset while its fourth element is being read.
        push_mv(1'b1, 8'h23, 10'h300, 3, 3, 3);
        base = ub_wr_cnt; cnt = 0;
        @(negedge CLK);
        EN = 1'b1;
        while (ub_wr_cnt < base + 3 && cnt < 100) begin
            @(negedge CLK); #1;
            cnt++;
        end
        chk("abort_reached", 32'(ub_wr_cnt), 32'(base + 3));
        @(negedge CLK);
        SYNC_RST = 1'b1; EN = 1'b0;
        @(negedge CLK);
        SYNC_RST = 1'b0;
        repeat (10) @(negedge CLK);
        chk("abort_wr_cnt", 32'(ub_wr_cnt), 32'(base + 3));
        chk("abort_drain", 32'(ub_exp.size()), 32'd0);
        chk_idle("abort");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
